// File: rtl/mul_share_arb.sv
// Round-robin sharing of one shift_add multiplier among NREQ requesters.
// Ports: i_req_* requests / o_req_ready grant, o_rsp_* response, o_mul_*/i_mul_* multiplier side.
module mul_share_arb #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*N-1:0] i_req_A,
  input  logic [NREQ*N-1:0] i_req_B,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  output logic [1:0]        o_rsp_id,
  output logic [2*N-1:0]    o_rsp_product,
  output logic              o_rsp_err,
  output logic [N-1:0]      o_mul_A,
  output logic [N-1:0]      o_mul_B,
  output logic              o_mul_start,
  output logic              o_mul_rstn,
  input  logic [2*N-1:0]    i_mul_product,
  input  logic              i_mul_stop
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    CLR
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       last_q;
  logic [1:0]       id_q;
  logic [1:0]       win_id;
  logic [2:0]       cand;
  logic             found;
  logic             accept;
  logic             timeout;
  logic [WDW-1:0]   wd_q;
  logic [NREQ-1:0]  grant;

  // Search starts one past the last winner and wraps.
  always_comb begin
    grant  = '0;
    win_id = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_q} + 3'(i);
      if (cand >= 3'(NREQ))
        cand = cand - 3'(NREQ);
      if (!found && i_req_valid[cand[1:0]]) begin
        found  = 1'b1;
        win_id = cand[1:0];
      end
    end
    if (found && state_q == IDLE && !i_rst)
      grant[win_id] = 1'b1;
  end

  assign o_req_ready = grant;
  assign accept      = |grant;
  assign timeout     = (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (i_mul_stop || timeout) state_d = DONE;
      DONE: state_d = CLR;
      CLR:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q        <= 2'(NREQ - 1);
      id_q          <= '0;
      wd_q          <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_id      <= '0;
      o_rsp_product <= '0;
      o_rsp_err     <= 1'b0;
      o_mul_A       <= '0;
      o_mul_B       <= '0;
      o_mul_start   <= 1'b0;
      o_mul_rstn    <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_mul_rstn  <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            o_mul_A     <= i_req_A[win_id*N +: N];
            o_mul_B     <= i_req_B[win_id*N +: N];
            id_q        <= win_id;
            last_q      <= win_id;
            o_mul_start <= 1'b1;
            wd_q        <= '0;
          end
        end
        BUSY: begin
          // Stop has priority over a coincident watchdog expiry.
          if (i_mul_stop) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_id      <= id_q;
            o_rsp_product <= i_mul_product;
            o_rsp_err     <= 1'b0;
            o_mul_start   <= 1'b0;
          end else if (timeout) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_id      <= id_q;
            o_rsp_product <= '0;
            o_rsp_err     <= 1'b1;
            o_mul_start   <= 1'b0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        DONE: o_mul_rstn <= 1'b0;
        CLR:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb with a behavioural multiplier.
// Grants checked against a round-robin model; responses popped from a queue.
module tb_mul_share_arb;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ*N-1:0] i_req_A;
  logic [NREQ*N-1:0] i_req_B;
  logic [NREQ-1:0]   o_req_ready;
  logic              o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic [2*N-1:0]    o_rsp_product;
  logic              o_rsp_err;
  logic [N-1:0]      o_mul_A;
  logic [N-1:0]      o_mul_B;
  logic              o_mul_start;
  logic              o_mul_rstn;
  logic [2*N-1:0]    i_mul_product;
  logic              i_mul_stop;

  mul_share_arb #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .i_req_A       (i_req_A),
    .i_req_B       (i_req_B),
    .o_req_ready   (o_req_ready),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_product (o_rsp_product),
    .o_rsp_err     (o_rsp_err),
    .o_mul_A       (o_mul_A),
    .o_mul_B       (o_mul_B),
    .o_mul_start   (o_mul_start),
    .o_mul_rstn    (o_mul_rstn),
    .i_mul_product (i_mul_product),
    .i_mul_stop    (i_mul_stop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [2*N-1:0] prod;
    logic           err;
    int             cyc;
  } exp_t;

  exp_t     exp_q[$];
  int       errors = 0;
  int       checks = 0;
  int       mul_lat = 10;
  int       mcnt = 0;
  int       cyc = 0;
  int       last_m = NREQ - 1;
  int       start_cyc = -1;
  int       rsp_cyc = -10;
  logic [N-1:0] exp_a;
  logic [N-1:0] exp_b;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Behavioural multiplier: stop after mul_lat started cycles; 0 = never.
  always @(negedge clk) begin
    if (i_rst || !o_mul_rstn || !o_mul_start) begin
      mcnt = 0;
      i_mul_stop = 1'b0;
      i_mul_product = '0;
    end else begin
      mcnt++;
      if (mul_lat != 0 && mcnt >= mul_lat) begin
        i_mul_stop = 1'b1;
        i_mul_product = 16'(o_mul_A) * 16'(o_mul_B);
      end
    end
  end

  function automatic int rr_winner(input logic [NREQ-1:0] v, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  // Monitor / checker.
  always @(negedge clk) begin
    int   w;
    exp_t e;
    logic [NREQ-1:0] g;
    cyc++;
    if (i_rst) begin
      exp_q.delete();
      last_m = NREQ - 1;
      start_cyc = -1;
      rsp_cyc = -10;
    end else begin
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(o_rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
          chk("rsp_product", 32'(o_rsp_product), 32'(e.prod));
          chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
        rsp_cyc = cyc;
      end
      if (cyc == rsp_cyc + 1) chk("rstn_low", 32'(o_mul_rstn), 0);
      if (cyc == rsp_cyc + 2) chk("rstn_high", 32'(o_mul_rstn), 1);
      if (cyc == start_cyc) begin
        chk("mul_start", 32'(o_mul_start), 1);
        chk("mul_A", 32'(o_mul_A), 32'(exp_a));
        chk("mul_B", 32'(o_mul_B), 32'(exp_b));
      end
      if (o_req_ready != 0) begin
        w = rr_winner(i_req_valid, last_m);
        g = '0;
        if (w >= 0) g[w] = 1'b1;
        chk("grant", 32'(o_req_ready), 32'(g));
        if (w >= 0) begin
          exp_a = i_req_A[w*N +: N];
          exp_b = i_req_B[w*N +: N];
          e.id  = w;
          e.err = (mul_lat == 0);
          e.prod = e.err ? '0 : 16'(exp_a) * 16'(exp_b);
          e.cyc = cyc + 1 + ((mul_lat == 0) ? TIMEOUT : mul_lat);
          exp_q.push_back(e);
          last_m = w;
          start_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic post(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    i_req_valid[k] = 1'b1;
    i_req_A[k*N +: N] = a;
    i_req_B[k*N +: N] = b;
  endtask

  task automatic step(output logic [NREQ-1:0] acc);
    @(negedge clk);
    acc = i_req_valid & o_req_ready;
    @(posedge clk);
    #1;
    i_req_valid = i_req_valid & ~acc;
  endtask

  task automatic drain();
    int n = 0;
    logic [NREQ-1:0] acc;
    while ((i_req_valid != 0 || exp_q.size() != 0) && n < 2000) begin
      step(acc);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
    end
    repeat (3) step(acc);
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, "_ready"}, 32'(o_req_ready), 0);
    chk({t, "_rstn"}, 32'(o_mul_rstn), 0);
    chk({t, "_start"}, 32'(o_mul_start), 0);
    chk({t, "_rsp_valid"}, 32'(o_rsp_valid), 0);
    chk({t, "_rsp_id"}, 32'(o_rsp_id), 0);
    chk({t, "_rsp_product"}, 32'(o_rsp_product), 0);
    chk({t, "_rsp_err"}, 32'(o_rsp_err), 0);
    chk({t, "_mul_A"}, 32'(o_mul_A), 0);
    chk({t, "_mul_B"}, 32'(o_mul_B), 0);
  endtask

  task automatic do_reset(input string t);
    i_rst = 1'b1;
    i_req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs(t);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] acc;
    int rem[NREQ];
    int posted;
    int lats[4];
    i_rst = 1'b1;
    i_req_valid = '0;
    i_req_A = '0;
    i_req_B = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset("por");

    mul_lat = 10;
    post(0, 8'h20, 8'h12);
    drain();

    do_reset("rst2");
    post(0, 8'h31, 8'h12);
    post(1, 8'h32, 8'h13);
    post(2, 8'h33, 8'h14);
    post(3, 8'h34, 8'h15);
    foreach (rem[k]) rem[k] = 1;
    for (int n = 0; n < 400 && i_req_valid != 0; n++) begin
      step(acc);
      for (int k = 0; k < NREQ; k++)
        if (acc[k] && rem[k] > 0) begin
          rem[k]--;
          post(k, 8'(8'h40 + k), 8'(8'h05 + k));
        end
    end
    drain();

    mul_lat = 0;
    post(1, 8'h7f, 8'h03);
    drain();
    mul_lat = 10;
    post(1, 8'h11, 8'h11);
    drain();

    mul_lat = TIMEOUT;
    post(2, 8'hff, 8'hff);
    drain();

    mul_lat = 20;
    post(3, 8'h0a, 8'h0b);
    repeat (6) step(acc);
    do_reset("midjob");
    mul_lat = 10;
    post(1, 8'h02, 8'h03);
    post(0, 8'h04, 8'h05);
    drain();

    lats[0] = 1;
    lats[1] = 3;
    lats[2] = 17;
    lats[3] = 2 * N + 2;
    foreach (lats[j]) begin
      mul_lat = lats[j];
      posted = 0;
      for (int n = 0; n < 3000 && posted < 12; n++) begin
        step(acc);
        for (int k = 0; k < NREQ; k++)
          if (!i_req_valid[k] && posted < 12 && $urandom_range(0, 3) == 0) begin
            post(k, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            posted++;
          end
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
